// File: rtl/alu_cmd_sequencer.sv
// Byte-to-ALU command sequencer: collects A, B, OP from uart_rx and launches one uart_tx per command.
// Optional inter-byte timeout is enabled with `define ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int NB_BITS       = 8,
  parameter int TIMEOUT_TICKS = 704,
  parameter int NB_TOUT       = 16,
  parameter int NB_DROP       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tick,
  input  logic [NB_BITS-1:0] i_alu_res,
  input  logic               i_tx_done,
  output logic [NB_BITS-1:0] o_A,
  output logic [NB_BITS-1:0] o_B,
  output logic [NB_BITS-1:0] o_OP,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [NB_DROP-1:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    START   = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [NB_BITS-1:0] a_q, a_d;
  logic [NB_BITS-1:0] b_q, b_d;
  logic [NB_BITS-1:0] op_q, op_d;
  logic [NB_BITS-1:0] res_q, res_d;
  logic [NB_DROP-1:0] drop_q, drop_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic               busy_st;
  logic               tmo_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [NB_TOUT-1:0] cnt_q, cnt_d;
  logic               in_get;

  // Counter restarts on every byte, so it measures the gap since the last one.
  always_comb begin
    in_get  = (state_q == GET_B) || (state_q == GET_OP);
    tmo_hit = in_get && !i_rx_done &&
              (cnt_q >= NB_TOUT'(TIMEOUT_TICKS));
    cnt_d   = cnt_q;
    if (!in_get || i_rx_done || tmo_hit) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_tout_cfg = TIMEOUT_TICKS + NB_TOUT;
  logic unused_tick;
  assign unused_tick = i_tick;
  assign tmo_hit     = 1'b0;
`endif

  always_comb begin
    busy_st = (state_q == EXEC) || (state_q == START) ||
              (state_q == WAIT_TX);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    drop_d  = drop_q;
    start_d = 1'b0;
    tmo_d   = 1'b0;

    // Bytes arriving while a command is in flight are discarded and counted.
    if (busy_st && i_rx_done && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = GET_OP;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GET_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data;
          state_d = EXEC;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d   = i_alu_res;
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == EXEC) || (state_d == START) ||
             (state_d == WAIT_TX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      drop_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      drop_q  <= drop_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  // A reset landing on the START cycle must not leak a start pulse.
  assign o_tx_start = start_q & ~reset;
  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_OP       = op_q;
  assign o_tx_data  = res_q;
  assign o_busy     = busy_q;
  assign o_timeout  = tmo_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer; a behavioural ALU closes the operand loop.
// Timeout expectations follow ALU_SEQ_TIMEOUT_EN.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tick;
  logic [7:0] alu_res;
  logic       tx_done;
  logic [7:0] o_A, o_B, o_OP, o_tx_data, o_drop_cnt;
  logic       o_tx_start, o_busy, o_timeout;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int tmo_cnt  = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_tick     (tick),
    .i_alu_res  (alu_res),
    .i_tx_done  (tx_done),
    .o_A        (o_A),
    .o_B        (o_B),
    .o_OP       (o_OP),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .o_drop_cnt (o_drop_cnt)
  );

  always_comb begin
    alu_res = 8'h00;
    case (o_OP)
      8'h20: alu_res = o_A + o_B;
      8'h22: alu_res = o_A - o_B;
      8'h24: alu_res = o_A & o_B;
      8'h25: alu_res = o_A | o_B;
      8'h26: alu_res = o_A ^ o_B;
      8'h27: alu_res = ~(o_A | o_B);
      default: alu_res = 8'h00;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the oldest pending command.
  always @(posedge clk) begin
    #1;
    if (o_timeout) tmo_cnt++;
    if (o_tx_start) begin
      exp_t e;
      starts++;
      if (sb.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_A", o_A, e.a);
        chk("sb_B", o_B, e.b);
        chk("sb_OP", o_OP, e.op);
        chk("sb_tx_data", o_tx_data, e.res);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic tx_pulse();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] res);
    sb.push_back({a, b, op, res});
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  initial begin
    int s0;
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tick    = 1'b0;
    tx_done = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_A", o_A, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_drop", o_drop_cnt, 0);

    // 1: basic ADD, start high two cycles after the OP byte cycle
    send_cmd(8'h09, 8'h0D, 8'h20, 8'h16);
    chk("t1_start_early", o_tx_start, 0);
    chk("t1_busy_exec", o_busy, 1);
    @(posedge clk); #1;
    chk("t1_start_lat2", o_tx_start, 1);
    @(posedge clk); #1;
    chk("t1_start_1cyc", o_tx_start, 0);
    chk("t1_busy_wait", o_busy, 1);

    // 2: byte during WAIT_TX is dropped
    send_byte(8'h55);
    chk("t2_drop1", o_drop_cnt, 1);
    chk("t2_A_kept", o_A, 8'h09);
    chk("t2_busy", o_busy, 1);
    tx_pulse();
    chk("t1_busy_low", o_busy, 0);
    send_cmd(8'h0F, 8'h03, 8'h22, 8'h0C);
    cycles(4);
    chk("t2_busy_wait", o_busy, 1);

    // 3: tx_done and rx_done together in WAIT_TX
    @(negedge clk);
    tx_done = 1'b1;
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    rx_done = 1'b0;
    chk("t3_idle", o_busy, 0);
    chk("t3_drop2", o_drop_cnt, 2);
    chk("t3_A_kept", o_A, 8'h0F);
    send_cmd(8'h01, 8'h02, 8'h25, 8'h03);
    cycles(4);
    tx_pulse();

    // 4: drop counter saturation
    send_cmd(8'h05, 8'h06, 8'h24, 8'h04);
    cycles(3);
    for (int i = 0; i < 260; i++) send_byte(8'h77);
    chk("t4_sat", o_drop_cnt, 8'hFF);
    for (int i = 0; i < 40; i++) send_byte(8'h78);
    chk("t4_sat_hold", o_drop_cnt, 8'hFF);
    chk("t4_A_kept", o_A, 8'h05);
    tx_pulse();

    // 5: reset mid-command
    send_byte(8'h09);
    send_byte(8'h0D);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_A_clr", o_A, 0);
    chk("t5_drop_clr", o_drop_cnt, 0);
    s0 = starts;
    send_cmd(8'h03, 8'h04, 8'h20, 8'h07);
    cycles(6);
    chk("t5_one_start", starts - s0, 1);
    chk("t5_A", o_A, 8'h03);
    chk("t5_B", o_B, 8'h04);
    chk("t5_tx_data", o_tx_data, 8'h07);
    tx_pulse();

    // 6: idle ticks after the first byte of a command
    send_byte(8'h09);
    for (int i = 0; i < 720; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
`ifdef ALU_SEQ_TIMEOUT_EN
    chk("t6_tmo_pulses", tmo_cnt, 1);
    send_byte(8'h11);
    chk("t6_A_reload", o_A, 8'h11);
    sb.push_back({8'h11, 8'h22, 8'h20, 8'h33});
    send_byte(8'h22);
    send_byte(8'h20);
`else
    chk("t6_no_tmo", tmo_cnt, 0);
    send_byte(8'h11);
    chk("t6_B_load", o_B, 8'h11);
    chk("t6_A_kept", o_A, 8'h09);
    sb.push_back({8'h09, 8'h11, 8'h20, 8'h1A});
    send_byte(8'h20);
`endif
    cycles(5);
    tx_pulse();
    cycles(3);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
